// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// baud divisor table derived from the system clock frequency.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Divisor rounded to nearest: clk cycles per oversample tick.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        return DIV_W'((clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud));
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Oversample tick generator: one-cycle sample_tick every baud_div() clocks.
// A change of baud_select restarts the divisor count from zero.
module baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [2:0]       sel_q;

    assign div = baud_div(CLK_HZ, baud_select);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            sel_q       <= '0;
            sample_tick <= 1'b0;
        end else begin
            sel_q       <= baud_select;
            sample_tick <= 1'b0;
            if (baud_select != sel_q) begin
                cnt <= '0;
            end else if (cnt == div - 1'b1) begin
                cnt         <= '0;
                sample_tick <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled start / 8 data / [even parity] / stop deframer
// with level-held result flags. Parity support is enabled by UART_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    logic                 sample_tick;
    logic                 rxd_meta, rxd_s;
    rx_state_t            state_q, state_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 armed_q, armed_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic                 par_q, par_d;
`endif

    baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .sample_tick (sample_tick)
    );

    // Synchroniser resets to the idle line level so reset release looks like idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        armed_d = armed_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        if (!Rx_EN) begin
            state_d = ST_IDLE;
            armed_d = 1'b0;
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rxd_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = ST_START;
                        tcnt_d  = '0;
                        valid_d = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd7) begin
                            if (!rxd_s) begin
                                state_d = ST_DATA;
                                tcnt_d  = '0;
                                bit_d   = '0;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                                state_d = ST_PARITY;
`else
                                state_d = ST_STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (sample_tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            par_d   = rxd_s;
                            state_d = ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (sample_tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            // Leaving at mid-stop lets a back-to-back start bit be seen.
                            data_d  = shreg_q;
                            ferr_d  = ~rxd_s;
`ifdef UART_PARITY_EN
                            perr_d  = ^{shreg_q, par_q};
                            valid_d = rxd_s & ~(^{shreg_q, par_q});
`else
                            perr_d  = 1'b0;
                            valid_d = rxd_s;
`endif
                            armed_d = rxd_s;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_FERROR = ferr_q;
`ifdef UART_PARITY_EN
    assign Rx_PERROR = perr_q;
`else
    assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 115200 baud (432 clk per bit).
// Honours UART_PARITY_EN the same way as the design.
module tb_uart_receiver;

    localparam int BIT_CLK = 432;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       rx_en;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perror;
    logic       rx_ferror;

    // Expected output state, updated from frame contents at frame boundaries.
    logic [7:0] exp_data;
    logic       exp_valid, exp_perr, exp_ferr;
    logic       chk_en;
    int         checks   = 0;
    int         failures = 0;

    uart_receiver #(.CLK_HZ(50_000_000)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Rx_EN       (rx_en),
        .RxD         (rxd),
        .Rx_DATA     (rx_data),
        .Rx_VALID    (rx_valid),
        .Rx_PERROR   (rx_perror),
        .Rx_FERROR   (rx_ferror)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("data",  rx_data,         exp_data);
            check("valid", {7'd0, rx_valid},  {7'd0, exp_valid});
            check("perr",  {7'd0, rx_perror}, {7'd0, exp_perr});
            check("ferr",  {7'd0, rx_ferror}, {7'd0, exp_ferr});
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        wait_clk(BIT_CLK);
    endtask

    // Start edge: flags must be cleared a few clocks after the falling edge.
    task automatic start_bit();
        chk_en = 1'b0;
        rxd    = 1'b0;
        wait_clk(10);
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        chk_en    = 1'b1;
        wait_clk(BIT_CLK - 10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        start_bit();
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        // Results land near mid-stop; mask that window, then expect the new values.
        rxd = stop;
        wait_clk(100);
        chk_en = 1'b0;
        wait_clk(200);
        exp_data  = d;
        exp_ferr  = ~stop;
`ifdef UART_PARITY_EN
        exp_perr  = bad_par;
`else
        exp_perr  = 1'b0;
`endif
        exp_valid = stop & ~exp_perr;
        chk_en    = 1'b1;
        wait_clk(BIT_CLK - 300);
    endtask

    initial begin
        logic [7:0] d55;
        chk_en      = 1'b0;
        reset       = 1'b1;
        rx_en       = 1'b1;
        rxd         = 1'b1;
        baud_select = 3'd7;
        exp_data    = 8'h00;
        exp_valid   = 1'b0;
        exp_perr    = 1'b0;
        exp_ferr    = 1'b0;
        wait_clk(5);
        @(negedge clk);
        check("rst_data",  rx_data,            8'h00);
        check("rst_valid", {7'd0, rx_valid},   8'h00);
        check("rst_perr",  {7'd0, rx_perror},  8'h00);
        check("rst_ferr",  {7'd0, rx_ferror},  8'h00);
        reset  = 1'b0;
        chk_en = 1'b1;
        wait_clk(100);

        // Good frame, then hold.
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_clk(300);
        check("a5_data",  rx_data,          8'hA5);
        check("a5_valid", {7'd0, rx_valid}, 8'h01);

        // Disable clears flags, keeps data.
        chk_en = 1'b0;
        rx_en  = 1'b0;
        wait_clk(3);
        exp_valid = 1'b0;
        chk_en    = 1'b1;
        wait_clk(50);
        check("dis_data",  rx_data,          8'hA5);
        check("dis_valid", {7'd0, rx_valid}, 8'h00);
        rx_en = 1'b1;
        wait_clk(50);

        // Bad parity bit.
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_clk(50);
        check("3c_data", rx_data, 8'h3C);
`ifdef UART_PARITY_EN
        check("3c_perr",  {7'd0, rx_perror}, 8'h01);
        check("3c_valid", {7'd0, rx_valid},  8'h00);
`else
        check("3c_perr",  {7'd0, rx_perror}, 8'h00);
        check("3c_valid", {7'd0, rx_valid},  8'h01);
`endif

        // Back-to-back, no idle gap.
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1);
        check("b2b_data",  rx_data,          8'h34);
        check("b2b_valid", {7'd0, rx_valid}, 8'h01);

        // Framing error then a held-low break line.
        send_frame(8'hFF, 1'b0, 1'b0);
        wait_clk(22 * BIT_CLK);
        check("brk_ferr",  {7'd0, rx_ferror}, 8'h01);
        check("brk_valid", {7'd0, rx_valid},  8'h00);
        check("brk_data",  rx_data,           8'hFF);
        rxd = 1'b1;
        wait_clk(100);

        // Short glitch: false start.
        chk_en = 1'b0;
        rxd    = 1'b0;
        wait_clk(10);
        exp_ferr = 1'b0;
        chk_en   = 1'b1;
        wait_clk(90);
        rxd = 1'b1;
        wait_clk(700);
        check("glitch_data",  rx_data,          8'hFF);
        check("glitch_valid", {7'd0, rx_valid}, 8'h00);

        // Reset in the middle of data bit 4 of 8'h55.
        d55 = 8'h55;
        start_bit();
        for (int i = 0; i < 4; i++) drive_bit(d55[i]);
        rxd = d55[4];
        wait_clk(200);
        reset     = 1'b1;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        rxd       = 1'b1;
        wait_clk(20);
        check("mrst_data", rx_data, 8'h00);
        reset = 1'b0;
        wait_clk(500);
        send_frame(8'h81, 1'b0, 1'b1);
        check("81_data",  rx_data,          8'h81);
        check("81_valid", {7'd0, rx_valid}, 8'h01);
        wait_clk(40);

        send_frame(8'h5A, 1'b0, 1'b1);
        check("5a_valid", {7'd0, rx_valid},  8'h01);
        check("5a_perr",  {7'd0, rx_perror}, 8'h00);

        // Randomised frames against the model.
        for (int n = 0; n < 4; n++) begin
            logic [7:0] d;
            logic       bp, st;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            bp  = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 3) != 0);
            gap = st ? $urandom_range(0, 1) * $urandom_range(0, 200) : 20 + $urandom_range(0, 200);
            rxd = 1'b1;
            wait_clk(gap);
            send_frame(d, bp, st);
        end
        rxd = 1'b1;
        wait_clk(100);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
